// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_pkg
//  Description : Shared state encoding and default widths for the systolic
//                feed sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package systolic_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      CLEAR = 3'd2,
      FEED  = 3'd3,
      DRAIN = 3'd4,
      DONE  = 3'd5
   } state_t;

   localparam int DEF_DIM = 32;
   localparam int SLOT_W  = $clog2(2*DEF_DIM-1);
   localparam int DIM_W   = $clog2(DEF_DIM)+1;

endpackage
`default_nettype wire

// File: rtl/systolic_feed_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_feed_sequencer_if
//  Description : Control/status bundle between the accelerator controller and
//                the feed sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface systolic_feed_sequencer_if #(
   parameter int DIM = systolic_pkg::DEF_DIM
);
   localparam int c_DIM_W  = $clog2(DIM)+1;
   localparam int c_SLOT_W = $clog2(2*DIM-1);

   logic                start;
   logic [c_DIM_W-1:0]  cfg_n;
   logic [c_DIM_W-1:0]  cfg_p;
   logic                mat_valid;
   logic                hold;
   logic [c_DIM_W-1:0]  lay_n;
   logic [c_DIM_W-1:0]  lay_p;
   logic [c_SLOT_W-1:0] slot_idx;
   logic                arr_en;
   logic                acc_clr;
   logic                busy;
   logic                done;
   logic                err;

   modport slave (
      input  start, cfg_n, cfg_p, mat_valid, hold,
      output lay_n, lay_p, slot_idx, arr_en, acc_clr, busy, done, err
   );

   modport master (
      output start, cfg_n, cfg_p, mat_valid, hold,
      input  lay_n, lay_p, slot_idx, arr_en, acc_clr, busy, done, err
   );
endinterface
`default_nettype wire

// File: rtl/seq_down_counter.sv
`default_nettype none
// ============================================================================
//  Module      : seq_down_counter
//  Description : Loadable down-counter with enable; flags a count of one.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_down_counter #(
   parameter int W = 8
) (
   input  wire logic         clk,
   input  wire logic         rst_n,
   input  wire logic         i_load,
   input  wire logic [W-1:0] i_load_val,
   input  wire logic         i_en,
   output logic              o_is_one
);
   logic [W-1:0] r_count;

   // Saturates at zero so a stray enable can never wrap the count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_en && (r_count != '0)) begin
         r_count <= r_count - W'(1);
      end
   end

   assign o_is_one = (r_count == W'(1));
endmodule
`default_nettype wire

// File: rtl/systolic_feed_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_feed_sequencer
//  Description : Steps skewed operand layouts into the systolic array one slot
//                per cycle, drains partial sums, then reports completion.
//  Revision    : 1.0 - initial release
// ============================================================================
module systolic_feed_sequencer
   import systolic_pkg::*;
#(
   parameter int BITS      = 8,
   parameter int DIM       = 32,
   parameter int DRAIN_CYC = 63
) (
   input  wire logic               clk,
   input  wire logic               rst_n,
   systolic_feed_sequencer_if.slave bus
);
   localparam int c_DIM_W   = $clog2(DIM)+1;
   localparam int c_SLOT_W  = $clog2(2*DIM-1);
   localparam int c_FEED_W  = c_DIM_W+1;
   localparam int c_DRAIN_W = $clog2(DRAIN_CYC)+1;
   localparam logic [c_SLOT_W-1:0] c_SLOT_TOP = c_SLOT_W'(2*DIM-2);

   if ((DRAIN_CYC < 1) || (BITS < 1)) begin : g_param_chk
      $error("systolic_feed_sequencer: DRAIN_CYC and BITS must be at least 1");
   end

   state_t                r_state;
   state_t                w_state_nxt;
   logic [c_DIM_W-1:0]    r_lay_n;
   logic [c_DIM_W-1:0]    r_lay_p;
   logic                  r_err;
   logic [c_SLOT_W-1:0]   r_slot;
   logic                  w_start_ok;
   logic                  w_cfg_bad;
   logic                  w_feed_step;
   logic                  w_drain_step;
   logic                  w_feed_one;
   logic                  w_drain_one;
   logic [c_FEED_W-1:0]   w_feed_init;

   assign w_start_ok   = (r_state == IDLE) && bus.start;
   assign w_cfg_bad    = (bus.cfg_n == '0) || (bus.cfg_n > c_DIM_W'(DIM)) ||
                         (bus.cfg_p == '0) || (bus.cfg_p > c_DIM_W'(DIM));
   assign w_feed_step  = (r_state == FEED)  && !bus.hold;
   assign w_drain_step = (r_state == DRAIN) && !bus.hold;
   // One extra bit so n+p-1 cannot overflow when both are DIM.
   assign w_feed_init  = c_FEED_W'(r_lay_n) + c_FEED_W'(r_lay_p) - c_FEED_W'(1);

   seq_down_counter #(.W(c_FEED_W)) u_feed_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (r_state == CLEAR),
      .i_load_val (w_feed_init),
      .i_en       (w_feed_step),
      .o_is_one   (w_feed_one)
   );

   seq_down_counter #(.W(c_DRAIN_W)) u_drain_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_feed_step && w_feed_one),
      .i_load_val (c_DRAIN_W'(DRAIN_CYC)),
      .i_en       (w_drain_step),
      .o_is_one   (w_drain_one)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (bus.start)                  w_state_nxt = w_cfg_bad ? DONE : LOAD;
         LOAD:    if (bus.mat_valid)              w_state_nxt = CLEAR;
         CLEAR:                                   w_state_nxt = FEED;
         FEED:    if (w_feed_step && w_feed_one)  w_state_nxt = DRAIN;
         DRAIN:   if (w_drain_step && w_drain_one) w_state_nxt = DONE;
         DONE:                                    w_state_nxt = IDLE;
         default:                                 w_state_nxt = IDLE;
      endcase
   end

   // Slot walks down from the top column; parked at zero while draining.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lay_n <= '0;
         r_lay_p <= '0;
         r_err   <= 1'b0;
         r_slot  <= c_SLOT_TOP;
      end else begin
         if (w_start_ok) begin
            r_lay_n <= bus.cfg_n;
            r_lay_p <= bus.cfg_p;
            r_err   <= w_cfg_bad;
         end
         if (r_state == CLEAR) begin
            r_slot <= c_SLOT_TOP;
         end else if (w_feed_step) begin
            r_slot <= w_feed_one ? '0 : r_slot - c_SLOT_W'(1);
         end else if (w_drain_step && w_drain_one) begin
            r_slot <= c_SLOT_TOP;
         end
      end
   end

   assign bus.lay_n    = r_lay_n;
   assign bus.lay_p    = r_lay_p;
   assign bus.slot_idx = r_slot;
   assign bus.arr_en   = ((r_state == FEED) || (r_state == DRAIN)) && !bus.hold;
   assign bus.acc_clr  = (r_state == CLEAR);
   assign bus.busy     = (r_state != IDLE);
   assign bus.done     = (r_state == DONE);
   assign bus.err      = (r_state == DONE) && r_err;
endmodule
`default_nettype wire

// File: tb/tb_systolic_feed_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_systolic_feed_sequencer
//  Description : Directed bench with a progress-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_feed_sequencer;
   localparam int DIM       = 32;
   localparam int DRAIN_CYC = 63;
   localparam int TOP       = 2*DIM-2;

   logic clk;
   logic rst_n;
   int   n_tests = 0;
   int   n_fail  = 0;

   systolic_feed_sequencer_if #(.DIM(DIM)) bus ();

   systolic_feed_sequencer #(.BITS(8), .DIM(DIM), .DRAIN_CYC(DRAIN_CYC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference: mode 0 idle, 1 wait operands, 2 clear, 3 active, 4 done.
   // m_k counts un-held active cycles; the first n+p-1 of them feed slots.
   int   m_mode, m_k, m_n, m_p;
   logic m_err;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_mode <= 0; m_k <= 0; m_n <= 0; m_p <= 0; m_err <= 1'b0;
      end else begin
         case (m_mode)
            0: if (bus.start) begin
                  m_n <= int'(bus.cfg_n);
                  m_p <= int'(bus.cfg_p);
                  if (bus.cfg_n == 0 || int'(bus.cfg_n) > DIM ||
                      bus.cfg_p == 0 || int'(bus.cfg_p) > DIM) begin
                     m_err <= 1'b1; m_mode <= 4;
                  end else begin
                     m_err <= 1'b0; m_mode <= 1;
                  end
               end
            1: if (bus.mat_valid) m_mode <= 2;
            2: begin m_k <= 0; m_mode <= 3; end
            3: if (!bus.hold) begin
                  m_k <= m_k + 1;
                  if (m_k + 1 == m_n + m_p - 1 + DRAIN_CYC) m_mode <= 4;
               end
            default: m_mode <= 0;
         endcase
      end
   end

   always @(negedge clk) begin
      chk("busy",    int'(bus.busy),    int'(m_mode != 0));
      chk("done",    int'(bus.done),    int'(m_mode == 4));
      chk("err",     int'(bus.err),     int'(m_mode == 4 && m_err));
      chk("acc_clr", int'(bus.acc_clr), int'(m_mode == 2));
      chk("arr_en",  int'(bus.arr_en),  int'(m_mode == 3 && !bus.hold));
      chk("lay_n",   int'(bus.lay_n),   m_n);
      chk("lay_p",   int'(bus.lay_p),   m_p);
      if (m_mode == 3)
         chk("slot_idx", int'(bus.slot_idx), (m_k < m_n + m_p - 1) ? TOP - m_k : 0);
      if (!rst_n)
         chk("rst_slot", int'(bus.slot_idx), TOP);
   end

   // Cycle c is the period after edge c, edge 0 being the edge that takes start.
   task automatic run(input string nm, input int n, input int p,
                      input int hold_from, input int hold_to, input int mv_from,
                      input int bstart_c, input int abort_c,
                      input int exp_done, input int exp_en, input int exp_clr,
                      input int exp_first, input int exp_err);
      int en_cnt = 0, clr_c = -1, done_c = -1, first_slot = -1, err_v = -1;
      @(posedge clk); #1;
      bus.start = 1'b1; bus.cfg_n = 6'(n); bus.cfg_p = 6'(p);
      bus.hold = 1'b0; bus.mat_valid = (mv_from <= 0);
      @(posedge clk); #1;
      for (int c = 0; c < 400; c++) begin
         bus.start     = (c == bstart_c);
         bus.cfg_n     = '0;
         bus.cfg_p     = 6'(DIM + 1);
         bus.hold      = (c >= hold_from && c <= hold_to);
         bus.mat_valid = (c >= mv_from);
         if (c == abort_c) begin
            #2 rst_n = 1'b0;
            #1;
            chk({nm, "_abort_busy"},   int'(bus.busy),     0);
            chk({nm, "_abort_arr_en"}, int'(bus.arr_en),   0);
            chk({nm, "_abort_slot"},   int'(bus.slot_idx), TOP);
            @(posedge clk);
            @(negedge clk);
            chk({nm, "_abort_done"},   int'(bus.done),     0);
            #2 rst_n = 1'b1;
            bus.start = 1'b0; bus.hold = 1'b0;
            return;
         end
         @(negedge clk);
         if (bus.arr_en) begin
            if (en_cnt == 0) first_slot = int'(bus.slot_idx);
            en_cnt++;
         end
         if (bus.acc_clr) clr_c = c;
         if (bus.done) begin
            done_c = c; err_v = int'(bus.err);
            break;
         end
         @(posedge clk); #1;
      end
      bus.start = 1'b0; bus.hold = 1'b0;
      chk({nm, "_done_cycle"}, done_c,     exp_done);
      chk({nm, "_err"},        err_v,      exp_err);
      chk({nm, "_en_cycles"},  en_cnt,     exp_en);
      chk({nm, "_clr_cycle"},  clr_c,      exp_clr);
      chk({nm, "_first_slot"}, first_slot, exp_first);
   endtask

   initial begin
      rst_n = 1'b0;
      bus.start = 1'b0; bus.cfg_n = '0; bus.cfg_p = '0;
      bus.mat_valid = 1'b0; bus.hold = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_slot", int'(bus.slot_idx), TOP);
      chk("reset_busy", int'(bus.busy), 0);
      rst_n = 1'b1;

      //   name        n   p  hf  ht  mv  bs  ab  done  en  clr  first err
      run("n4p4",      4,  4, -1, -1,  0, -1, -1,  72,  70,  1,  62,  0);
      run("n32p32",   32, 32, -1, -1,  0, -1, -1, 128, 126,  1,  62,  0);
      run("n1p1",      1,  1, -1, -1,  0, -1, -1,  66,  64,  1,  62,  0);
      run("p0",        4,  0, -1, -1,  0, -1, -1,   0,   0, -1,  -1,  1);
      run("n33",      33,  4, -1, -1,  0, -1, -1,   0,   0, -1,  -1,  1);
      run("hold5",     4,  4,  4,  8,  0, -1, -1,  77,  70,  1,  62,  0);
      run("mv_late",   2,  3, -1, -1,  3, -1, -1,  72,  67,  4,  62,  0);
      run("abort",     4,  4, -1, -1,  0, -1, 20,   0,   0,  0,   0,  0);
      run("busystart", 4,  4, -1, -1,  0,  5, -1,  72,  70,  1,  62,  0);

      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/systolic_feed_sequencer.md
Name: systolic_feed_sequencer

Overview:
- Control FSM that steps the skewed operand layouts into the systolic array, one wavefront column (slot) per cycle.
- Latches the matrix dimensions, emits the slot index used to select the current column of the A and B layout outputs, and gates the array enable.
- Runs a drain phase so partial sums finish propagating, then reports completion to the top-level accelerator controller.
- Sits between the accelerator control/memory-load logic and the layoutA/layoutB plus systolic-array datapath.

Parameters:
- BITS, 8, bit width of each operand element; passed through for width consistency only.
- DIM, 32, maximum matrix dimension; the layout has 2*DIM-1 slots.
- DRAIN_CYC, 63, cycles the array keeps running after the last feed slot; must be at least 1.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a multiply; ignored unless busy=0
- cfg_n  in  $clog2(DIM)+1  B row count (n); sampled on accepted start
- cfg_p  in  $clog2(DIM)+1  B column count (p); sampled on accepted start
- mat_valid  in  1  operand matrices are loaded and stable at the layout inputs
- hold  in  1  downstream stall; freezes FEED and DRAIN progress
- lay_n  out  $clog2(DIM)+1  latched n, driven to the layout n port
- lay_p  out  $clog2(DIM)+1  latched p, driven to the layout p port
- slot_idx  out  $clog2(2*DIM-1)  layout column currently presented to the array
- arr_en  out  1  array shift/accumulate enable
- acc_clr  out  1  one-cycle accumulator clear
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  qualifies done; set when the configuration was illegal

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE. All outputs 0 except slot_idx=2*DIM-2. All counters are cleared. Reset in any state aborts the operation immediately, with no done pulse.
- IDLE:
  - start=1 latches cfg_n and cfg_p into lay_n and lay_p.
  - If either value is 0 or greater than DIM, go to DONE with err=1.
  - Otherwise go to LOAD.
  - start while busy=1 is ignored and has no side effects.
- LOAD: wait for mat_valid=1, then go to CLEAR. Outputs stay idle.
- CLEAR:
  - Exactly one cycle with acc_clr=1 and arr_en=0.
  - Load feed_cnt=lay_n+lay_p-1 and set slot_idx=2*DIM-2.
  - Go to FEED.
- FEED:
  - arr_en = !hold.
  - On each cycle with hold=0: if feed_cnt is 1, load drain_cnt=DRAIN_CYC and go to DRAIN; otherwise decrement slot_idx and feed_cnt.
  - hold=1 freezes slot_idx and feed_cnt.
  - The last slot presented is 2*DIM-lay_n-lay_p, which is never negative because n,p <= DIM.
- DRAIN:
  - slot_idx = 0 and the layout output for it must not be consumed. The array treats arr_en in DRAIN as a zero-injection shift.
  - arr_en = !hold. drain_cnt decrements only when hold=0.
  - When drain_cnt is 1 and hold=0, go to DONE.
- DONE: done=1 for one cycle, with err as determined at start. Then go to IDLE. lay_n and lay_p keep their values until the next accepted start.
- mat_valid deasserting after LOAD is ignored; the operands are expected to remain stable, and this is not checked.
- hold is ignored in IDLE, LOAD, CLEAR and DONE.
- Arithmetic:
  - Feed count is lay_n+lay_p-1, computed at $clog2(DIM)+2 bits to avoid overflow.
  - slot_idx is unsigned and never wraps.
  - drain_cnt is $clog2(DRAIN_CYC)+1 bits.
- Latency with no hold and mat_valid already high: done asserts in cycle 2+(n+p-1)+DRAIN_CYC after the start edge.

Decomposition:
- Shared package systolic_pkg holds:
  - state enum {IDLE, LOAD, CLEAR, FEED, DRAIN, DONE};
  - localparams SLOT_W=$clog2(2*DIM-1) and DIM_W=$clog2(DIM)+1.
- One sub-module, seq_down_counter: loadable down-counter with enable and "is_one" flag, instantiated for both feed_cnt and drain_cnt.

Test Plan:
- n=4, p=4, DIM=32, DRAIN_CYC=63, mat_valid high, no hold: slot_idx goes 62..56 over 7 arr_en cycles; acc_clr pulses 1 cycle before the first slot; done pulses at cycle 72 with err=0.
- n=32, p=32: 63 feed cycles with slot_idx 62 down to 0; done at cycle 2+63+63=128.
- n=1, p=1: single feed slot at slot_idx=62; done at cycle 66.
- cfg_p=0, or cfg_n=33: done and err pulse in the cycle after start; arr_en and acc_clr never assert.
- hold=1 for 5 cycles mid-FEED (n=p=4): arr_en goes low and slot_idx freezes for those 5 cycles; done is delayed by exactly 5 cycles (cycle 77).
- rst_n low in DRAIN, then a new start: outputs return to reset values asynchronously with no done pulse; the next run completes normally. A start issued while busy during that run is ignored.
